// File: rtl/packet_scheduler.sv
// Chooses the data-island packet for each packet slot: ACR first, then audio, then
// round-robin InfoFrames, else a null packet. The selected packet is registered for the assembler.
module packet_scheduler #(
    parameter int NUM_INFOFRAMES   = 3,
    parameter int INFOFRAME_PERIOD = 1,
    parameter int AUDIO_DEPTH      = 4
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          packet_slot,
    input  logic                          acr_req,
    input  logic                          audio_req,
    input  logic [23:0]                   acr_header,
    input  logic [223:0]                  acr_sub,
    input  logic [23:0]                   audio_header,
    input  logic [223:0]                  audio_sub,
    input  logic [24*NUM_INFOFRAMES-1:0]  if_header,
    input  logic [224*NUM_INFOFRAMES-1:0] if_sub,
    output logic [23:0]                   header,
    output logic [55:0]                   sub [3:0],
    output logic [1:0]                    packet_kind,
    output logic [2:0]                    packet_index,
    output logic                          acr_ack,
    output logic                          audio_ack,
    output logic                          audio_overflow,
    output logic                          infoframe_missed
);

    localparam logic [1:0] KIND_NULL  = 2'd0;
    localparam logic [1:0] KIND_ACR   = 2'd1;
    localparam logic [1:0] KIND_AUDIO = 2'd2;
    localparam logic [1:0] KIND_IF    = 2'd3;

    logic                      acr_pending_q, acr_pending_d;
    logic [3:0]                audio_count_q, audio_count_d;
    logic [NUM_INFOFRAMES-1:0] if_pending_q, if_pending_d;
    logic [2:0]                rr_ptr_q, rr_ptr_d;
    logic [7:0]                frame_cnt_q, frame_cnt_d;
    logic [23:0]               header_q, header_d;
    logic [55:0]               sub_q [3:0];
    logic [55:0]               sub_d [3:0];
    logic [1:0]                kind_q, kind_d;
    logic [2:0]                index_q, index_d;
    logic                      acr_ack_q, acr_ack_d;
    logic                      audio_ack_q, audio_ack_d;
    logic                      overflow_q, overflow_d;
    logic                      missed_q, missed_d;

    logic       grant_acr, grant_audio, grant_if;
    logic       if_found;
    logic [2:0] if_idx;
    logic [3:0] cand;
    logic [7:0] if_pend_pad;
    logic [7:0] grant_onehot;
    logic       period_restart;
    logic [223:0] src_sub;

    // Round-robin search: first pending InfoFrame at or after rr_ptr, wrapping.
    always_comb begin
        if_found    = 1'b0;
        if_idx      = 3'd0;
        cand        = 4'd0;
        if_pend_pad = 8'(if_pending_q);
        for (int off = 0; off < NUM_INFOFRAMES; off++) begin
            cand = {1'b0, rr_ptr_q} + 4'(off);
            if (cand >= 4'(NUM_INFOFRAMES)) begin
                cand = cand - 4'(NUM_INFOFRAMES);
            end
            if (!if_found && if_pend_pad[cand[2:0]]) begin
                if_found = 1'b1;
                if_idx   = cand[2:0];
            end
        end
    end

    assign grant_acr      = packet_slot && acr_pending_q;
    assign grant_audio    = packet_slot && !acr_pending_q && (audio_count_q != 4'd0);
    assign grant_if       = packet_slot && !acr_pending_q && (audio_count_q == 4'd0) && if_found;
    assign period_restart = frame_start && (frame_cnt_q == 8'd0);
    assign grant_onehot   = 8'b1 << if_idx;

    always_comb begin
        acr_pending_d = acr_pending_q;
        audio_count_d = audio_count_q;
        if_pending_d  = if_pending_q;
        rr_ptr_d      = rr_ptr_q;
        frame_cnt_d   = frame_cnt_q;
        overflow_d    = overflow_q;
        missed_d      = missed_q;

        // A new request beats a grant in the same cycle.
        if (acr_req) begin
            acr_pending_d = 1'b1;
        end else if (grant_acr) begin
            acr_pending_d = 1'b0;
        end

        if (audio_req && !grant_audio) begin
            if (audio_count_q == 4'(AUDIO_DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                audio_count_d = audio_count_q + 4'd1;
            end
        end else if (!audio_req && grant_audio) begin
            audio_count_d = audio_count_q - 4'd1;
        end

        if (grant_if) begin
            if_pending_d = if_pending_q & ~grant_onehot[NUM_INFOFRAMES-1:0];
            rr_ptr_d     = (if_idx == 3'(NUM_INFOFRAMES - 1)) ? 3'd0 : if_idx + 3'd1;
        end

        // Missed detection looks at the pending set before this cycle's grant.
        if (period_restart) begin
            if_pending_d = '1;
            if (|if_pending_q) begin
                missed_d = 1'b1;
            end
        end

        if (frame_start) begin
            frame_cnt_d = (frame_cnt_q == 8'(INFOFRAME_PERIOD - 1)) ? 8'd0 : frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        header_d    = header_q;
        sub_d       = sub_q;
        kind_d      = kind_q;
        index_d     = index_q;
        acr_ack_d   = grant_acr;
        audio_ack_d = grant_audio;
        src_sub     = '0;

        if (packet_slot) begin
            header_d = 24'd0;
            kind_d   = KIND_NULL;
            index_d  = 3'd0;
            if (grant_acr) begin
                header_d = acr_header;
                src_sub  = acr_sub;
                kind_d   = KIND_ACR;
            end else if (grant_audio) begin
                header_d = audio_header;
                src_sub  = audio_sub;
                kind_d   = KIND_AUDIO;
            end else if (grant_if) begin
                header_d = if_header[24*if_idx +: 24];
                src_sub  = if_sub[224*if_idx +: 224];
                kind_d   = KIND_IF;
                index_d  = if_idx;
            end
            for (int i = 0; i < 4; i++) begin
                sub_d[i] = src_sub[56*i +: 56];
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            acr_pending_q <= 1'b0;
            audio_count_q <= 4'd0;
            if_pending_q  <= '0;
            rr_ptr_q      <= 3'd0;
            frame_cnt_q   <= 8'd0;
            header_q      <= 24'd0;
            for (int i = 0; i < 4; i++) begin
                sub_q[i] <= 56'd0;
            end
            kind_q        <= KIND_NULL;
            index_q       <= 3'd0;
            acr_ack_q     <= 1'b0;
            audio_ack_q   <= 1'b0;
            overflow_q    <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            acr_pending_q <= acr_pending_d;
            audio_count_q <= audio_count_d;
            if_pending_q  <= if_pending_d;
            rr_ptr_q      <= rr_ptr_d;
            frame_cnt_q   <= frame_cnt_d;
            header_q      <= header_d;
            for (int i = 0; i < 4; i++) begin
                sub_q[i] <= sub_d[i];
            end
            kind_q        <= kind_d;
            index_q       <= index_d;
            acr_ack_q     <= acr_ack_d;
            audio_ack_q   <= audio_ack_d;
            overflow_q    <= overflow_d;
            missed_q      <= missed_d;
        end
    end

    assign header           = header_q;
    assign sub              = sub_q;
    assign packet_kind      = kind_q;
    assign packet_index     = index_q;
    assign acr_ack          = acr_ack_q;
    assign audio_ack        = audio_ack_q;
    assign audio_overflow   = overflow_q;
    assign infoframe_missed = missed_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: one default instance plus one with a two-frame
// InfoFrame period, both fed the same stimulus.
module tb_packet_scheduler;

    localparam logic [55:0] ACR_S0 = 56'hA0A0A0A0A0A0A0;
    localparam logic [55:0] ACR_S1 = 56'hA1A1A1A1A1A1A1;
    localparam logic [55:0] ACR_S2 = 56'hA2A2A2A2A2A2A2;
    localparam logic [55:0] ACR_S3 = 56'hA3A3A3A3A3A3A3;
    localparam logic [55:0] AUD_S0 = 56'hB0B0B0B0B0B0B0;
    localparam logic [55:0] AUD_S3 = 56'hB3B3B3B3B3B3B3;
    localparam logic [55:0] IF0_S  = 56'hD0D0D0D0D0D0D0;
    localparam logic [55:0] IF1_S  = 56'hD1D1D1D1D1D1D1;
    localparam logic [55:0] IF2_S  = 56'hD2D2D2D2D2D2D2;
    localparam logic [23:0] ACR_H  = 24'hA5A5A5;
    localparam logic [23:0] AUD_H  = 24'hB5B5B5;
    localparam logic [23:0] IF0_H  = 24'hC0C0C0;
    localparam logic [23:0] IF1_H  = 24'hC1C1C1;
    localparam logic [23:0] IF2_H  = 24'hC2C2C2;

    logic         clk_pixel = 1'b0;
    logic         reset = 1'b0;
    logic         frame_start = 1'b0;
    logic         packet_slot = 1'b0;
    logic         acr_req = 1'b0;
    logic         audio_req = 1'b0;
    logic [23:0]  acr_header = ACR_H;
    logic [223:0] acr_sub = {ACR_S3, ACR_S2, ACR_S1, ACR_S0};
    logic [23:0]  audio_header = AUD_H;
    logic [223:0] audio_sub = {AUD_S3, 56'hB2B2B2B2B2B2B2, 56'hB1B1B1B1B1B1B1, AUD_S0};
    logic [71:0]  if_header = {IF2_H, IF1_H, IF0_H};
    logic [671:0] if_sub = {{4{IF2_S}}, {4{IF1_S}}, {4{IF0_S}}};

    logic [23:0] header;
    logic [55:0] sub_o [3:0];
    logic [1:0]  packet_kind;
    logic [2:0]  packet_index;
    logic        acr_ack, audio_ack, audio_overflow, infoframe_missed;

    logic [23:0] p2_header;
    logic [55:0] p2_sub [3:0];
    logic [1:0]  p2_kind;
    logic [2:0]  p2_index;
    logic        p2_acr_ack, p2_audio_ack, p2_overflow, p2_missed;

    int checks = 0;
    int failures = 0;

    always #5 clk_pixel = ~clk_pixel;

    packet_scheduler u_dut (
        .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start),
        .packet_slot(packet_slot), .acr_req(acr_req), .audio_req(audio_req),
        .acr_header(acr_header), .acr_sub(acr_sub), .audio_header(audio_header),
        .audio_sub(audio_sub), .if_header(if_header), .if_sub(if_sub),
        .header(header), .sub(sub_o), .packet_kind(packet_kind),
        .packet_index(packet_index), .acr_ack(acr_ack), .audio_ack(audio_ack),
        .audio_overflow(audio_overflow), .infoframe_missed(infoframe_missed)
    );

    packet_scheduler #(.INFOFRAME_PERIOD(2)) u_dut_p2 (
        .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start),
        .packet_slot(packet_slot), .acr_req(acr_req), .audio_req(audio_req),
        .acr_header(acr_header), .acr_sub(acr_sub), .audio_header(audio_header),
        .audio_sub(audio_sub), .if_header(if_header), .if_sub(if_sub),
        .header(p2_header), .sub(p2_sub), .packet_kind(p2_kind),
        .packet_index(p2_index), .acr_ack(p2_acr_ack), .audio_ack(p2_audio_ack),
        .audio_overflow(p2_overflow), .infoframe_missed(p2_missed)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic slot();
        packet_slot = 1'b1;
        cycle();
        packet_slot = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (header !== 24'd0 || packet_kind !== 2'd0 || packet_index !== 3'd0) begin
            failures++;
            $display("FAIL reset_pkt: header=%h kind=%0d index=%0d required 0/0/0", header, packet_kind, packet_index);
        end
        checks++;
        if (sub_o[0] !== 56'd0 || sub_o[3] !== 56'd0) begin
            failures++;
            $display("FAIL reset_sub: sub0=%h sub3=%h required 0", sub_o[0], sub_o[3]);
        end
        checks++;
        if ({acr_ack, audio_ack, audio_overflow, infoframe_missed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0000", {acr_ack, audio_ack, audio_overflow, infoframe_missed});
        end
    endtask

    task automatic test_infoframe_rr();
        logic [23:0] exp_h [3];
        logic [55:0] exp_s [3];
        exp_h[0] = IF0_H; exp_h[1] = IF1_H; exp_h[2] = IF2_H;
        exp_s[0] = IF0_S; exp_s[1] = IF1_S; exp_s[2] = IF2_S;
        pulse_frame();
        for (int k = 0; k < 3; k++) begin
            slot();
            checks++;
            if (packet_kind !== 2'd3 || packet_index !== 3'(k) || header !== exp_h[k]) begin
                failures++;
                $display("FAIL if_rr_%0d: kind=%0d index=%0d header=%h required 3/%0d/%h",
                         k, packet_kind, packet_index, header, k, exp_h[k]);
            end
            checks++;
            if (sub_o[0] !== exp_s[k] || sub_o[3] !== exp_s[k]) begin
                failures++;
                $display("FAIL if_sub_%0d: sub0=%h sub3=%h required %h", k, sub_o[0], sub_o[3], exp_s[k]);
            end
        end
        cycle();
        checks++;
        if (packet_kind !== 2'd3 || packet_index !== 3'd2) begin
            failures++;
            $display("FAIL if_hold: kind=%0d index=%0d required 3/2", packet_kind, packet_index);
        end
        slot();
        checks++;
        if (packet_kind !== 2'd0 || header !== 24'd0 || sub_o[1] !== 56'd0 || packet_index !== 3'd0) begin
            failures++;
            $display("FAIL if_null: kind=%0d header=%h sub1=%h index=%0d required 0/0/0/0",
                     packet_kind, header, sub_o[1], packet_index);
        end
    endtask

    task automatic test_priority();
        pulse_frame();
        acr_req = 1'b1;
        audio_req = 1'b1;
        cycle();
        acr_req = 1'b0;
        audio_req = 1'b0;
        packet_slot = 1'b1;
        cycle();
        checks++;
        if (packet_kind !== 2'd1 || header !== ACR_H || sub_o[2] !== ACR_S2 || acr_ack !== 1'b1 || audio_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_acr: kind=%0d header=%h sub2=%h acr_ack=%b audio_ack=%b required 1/%h/%h/1/0",
                     packet_kind, header, sub_o[2], acr_ack, audio_ack, ACR_H, ACR_S2);
        end
        cycle();
        checks++;
        if (packet_kind !== 2'd2 || header !== AUD_H || sub_o[0] !== AUD_S0 || acr_ack !== 1'b0 || audio_ack !== 1'b1) begin
            failures++;
            $display("FAIL prio_audio: kind=%0d header=%h sub0=%h acr_ack=%b audio_ack=%b required 2/%h/%h/0/1",
                     packet_kind, header, sub_o[0], acr_ack, audio_ack, AUD_H, AUD_S0);
        end
        cycle();
        checks++;
        if (packet_kind !== 2'd3 || packet_index !== 3'd0 || audio_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_if: kind=%0d index=%0d audio_ack=%b required 3/0/0", packet_kind, packet_index, audio_ack);
        end
        cycle();
        cycle();
        packet_slot = 1'b0;
        checks++;
        if (packet_kind !== 2'd3 || packet_index !== 3'd2) begin
            failures++;
            $display("FAIL prio_drain: kind=%0d index=%0d required 3/2", packet_kind, packet_index);
        end
        cycle();
        checks++;
        if (acr_ack !== 1'b0 || audio_ack !== 1'b0 || infoframe_missed !== 1'b0 || packet_kind !== 2'd3) begin
            failures++;
            $display("FAIL prio_idle: acr_ack=%b audio_ack=%b missed=%b kind=%0d required 0/0/0/3",
                     acr_ack, audio_ack, infoframe_missed, packet_kind);
        end
    endtask

    task automatic fill_audio(input int n);
        for (int i = 0; i < n; i++) begin
            audio_req = 1'b1;
            cycle();
            audio_req = 1'b0;
            cycle();
        end
    endtask

    task automatic drain_audio(input string name, input int n_audio);
        for (int i = 0; i <= n_audio; i++) begin
            slot();
            checks++;
            if (i < n_audio && (packet_kind !== 2'd2 || audio_ack !== 1'b1)) begin
                failures++;
                $display("FAIL %s_audio_%0d: kind=%0d ack=%b required 2/1", name, i, packet_kind, audio_ack);
            end else if (i == n_audio && (packet_kind !== 2'd0 || audio_ack !== 1'b0)) begin
                failures++;
                $display("FAIL %s_null: kind=%0d ack=%b required 0/0", name, packet_kind, audio_ack);
            end
        end
    endtask

    task automatic test_full_simultaneous();
        fill_audio(4);
        checks++;
        if (audio_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_no_ovf: overflow=%b required 0", audio_overflow);
        end
        audio_req = 1'b1;
        slot();
        audio_req = 1'b0;
        checks++;
        if (packet_kind !== 2'd2 || audio_ack !== 1'b1 || audio_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_simul: kind=%0d ack=%b overflow=%b required 2/1/0", packet_kind, audio_ack, audio_overflow);
        end
        drain_audio("full_keep4", 4);
    endtask

    task automatic test_overflow();
        fill_audio(5);
        checks++;
        if (audio_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: overflow=%b required 1", audio_overflow);
        end
        drain_audio("overflow", 4);
        checks++;
        if (audio_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: overflow=%b required 1", audio_overflow);
        end
    endtask

    task automatic test_period();
        do_reset();
        pulse_frame();
        cycle();
        pulse_frame();
        cycle();
        checks++;
        if (p2_missed !== 1'b0 || infoframe_missed !== 1'b1) begin
            failures++;
            $display("FAIL period_f2: p2_missed=%b p1_missed=%b required 0/1", p2_missed, infoframe_missed);
        end
        pulse_frame();
        checks++;
        if (p2_missed !== 1'b1) begin
            failures++;
            $display("FAIL period_f3: p2_missed=%b required 1", p2_missed);
        end
        pulse_frame();

        do_reset();
        pulse_frame();
        for (int k = 0; k < 3; k++) begin
            slot();
            checks++;
            if (p2_kind !== 2'd3 || p2_index !== 3'(k)) begin
                failures++;
                $display("FAIL period_f1_slot%0d: kind=%0d index=%0d required 3/%0d", k, p2_kind, p2_index, k);
            end
        end
        pulse_frame();
        slot();
        checks++;
        if (p2_kind !== 2'd0) begin
            failures++;
            $display("FAIL period_f2_null: kind=%0d required 0", p2_kind);
        end
        pulse_frame();
        slot();
        slot();
        slot();
        checks++;
        if (p2_kind !== 2'd3 || p2_index !== 3'd2) begin
            failures++;
            $display("FAIL period_f3_slot: kind=%0d index=%0d required 3/2", p2_kind, p2_index);
        end
        pulse_frame();
        checks++;
        if (p2_missed !== 1'b0) begin
            failures++;
            $display("FAIL period_no_miss: p2_missed=%b required 0", p2_missed);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_frame();
        slot();
        checks++;
        if (packet_kind !== 2'd3 || header !== IF0_H) begin
            failures++;
            $display("FAIL areset_pre: kind=%0d header=%h required 3/%h", packet_kind, header, IF0_H);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (header !== 24'd0 || packet_kind !== 2'd0 || packet_index !== 3'd0 || sub_o[0] !== 56'd0) begin
            failures++;
            $display("FAIL areset_now: header=%h kind=%0d index=%0d sub0=%h required 0",
                     header, packet_kind, packet_index, sub_o[0]);
        end
        cycle();
        reset = 1'b1;
        cycle();
        slot();
        checks++;
        if (packet_kind !== 2'd0 || header !== 24'd0) begin
            failures++;
            $display("FAIL areset_null: kind=%0d header=%h required 0/0", packet_kind, header);
        end
    endtask

    initial begin
        test_reset();
        test_infoframe_rr();
        test_priority();
        test_full_simultaneous();
        test_overflow();
        test_period();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
